// File: rtl/l2_arbiter_if.sv
// Bundle of the two client ports (I, D) and the L2 bus seen by l2_arbiter.
// Handshake: a client holds x_start high with stable addr/data/we until x_done pulses for one
// cycle, then drops it; the L2 side is the same with l2_start held until the l2_done pulse.
interface l2_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] i_addr;
  logic              i_start;
  logic [DATA_W-1:0] i_q;
  logic              i_done;

  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data;
  logic              d_we;
  logic              d_start;
  logic [DATA_W-1:0] d_q;
  logic              d_done;

  logic [ADDR_W-1:0] l2_addr;
  logic [DATA_W-1:0] l2_data;
  logic              l2_we;
  logic              l2_start;
  logic [DATA_W-1:0] l2_q;
  logic              l2_done;

  modport slave (
    input  i_addr, i_start, d_addr, d_data, d_we, d_start, l2_q, l2_done,
    output i_q, i_done, d_q, d_done, l2_addr, l2_data, l2_we, l2_start
  );

  modport master (
    output i_addr, i_start, d_addr, d_data, d_we, d_start, l2_q, l2_done,
    input  i_q, i_done, d_q, d_done, l2_addr, l2_data, l2_we, l2_start
  );
endinterface

// File: rtl/l2_arbiter.sv
// Two-client (instruction fetch / data) arbiter in front of the L2 cache bus: one latched
// request at a time, a guaranteed low cycle on l2_start between transactions, result routed to the owner.
module l2_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  l2_arbiter_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic served_i;
  logic served_d;
  logic last_d;
  logic owner_d;
  logic abort;

  logic req_i;
  logic req_d;
  logic grant_d;
  logic grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic owner_start;
  logic deliver;

  // served_x masks a start that is still high right after its own done pulse.
  assign req_i = bus.i_start & ~served_i;
  assign req_d = bus.d_start & ~served_d;

  assign owner_start = owner_d ? bus.d_start : bus.i_start;
  assign deliver     = (state == S_WAIT) & bus.l2_done & ~abort & owner_start;
  assign dbg_state   = state;

  always_comb begin
    grant_d = 1'b0;
    if (req_d && req_i) begin
      grant_d = RR_EN ? ~last_d : 1'b1;
    end else if (req_d) begin
      grant_d = 1'b1;
    end
    grant_addr = grant_d ? bus.d_addr : bus.i_addr;
    grant_data = grant_d ? bus.d_data : '0;
    grant_we   = grant_d & bus.d_we;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_i || req_d) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (bus.l2_done) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      served_i     <= 1'b0;
      served_d     <= 1'b0;
      last_d       <= 1'b0;
      owner_d      <= 1'b0;
      abort        <= 1'b0;
      bus.l2_addr  <= '0;
      bus.l2_data  <= '0;
      bus.l2_we    <= 1'b0;
      bus.l2_start <= 1'b0;
      bus.i_q      <= '0;
      bus.i_done   <= 1'b0;
      bus.d_q      <= '0;
      bus.d_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;

      if (deliver && !owner_d) begin
        served_i <= 1'b1;
      end else if (!bus.i_start) begin
        served_i <= 1'b0;
      end

      if (deliver && owner_d) begin
        served_d <= 1'b1;
      end else if (!bus.d_start) begin
        served_d <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (req_i || req_d) begin
            owner_d      <= grant_d;
            last_d       <= grant_d;
            bus.l2_addr  <= grant_addr;
            bus.l2_data  <= grant_data;
            bus.l2_we    <= grant_we;
            bus.l2_start <= 1'b1;
          end
        end
        S_ISSUE, S_WAIT: begin
          // An abandoned request still runs to completion on L2; only its result is dropped.
          if (!owner_start) abort <= 1'b1;
          if (state == S_WAIT && bus.l2_done) begin
            bus.l2_start <= 1'b0;
            if (deliver) begin
              if (owner_d) begin
                bus.d_q    <= bus.l2_q;
                bus.d_done <= 1'b1;
              end else begin
                bus.i_q    <= bus.l2_q;
                bus.i_done <= 1'b1;
              end
            end
          end
        end
        S_GAP: abort <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: a round-robin and a fixed-priority instance share one L2 memory model;
// use_fp selects which instance the client stimulus reaches and which outputs are observed.
module tb_l2_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic use_fp = 1'b0;

  logic [23:0] i_addr = '0;
  logic        i_start = 1'b0;
  logic [23:0] d_addr = '0;
  logic [31:0] d_data = '0;
  logic        d_we = 1'b0;
  logic        d_start = 1'b0;

  logic [31:0] m_q = '0;
  logic        m_done = 1'b0;
  logic [1:0]  dbg_r;
  logic [1:0]  dbg_f;

  l2_arbiter_if #(.ADDR_W(24), .DATA_W(32)) rb ();
  l2_arbiter_if #(.ADDR_W(24), .DATA_W(32)) fb ();

  l2_arbiter #(.ADDR_W(24), .DATA_W(32), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .bus(rb), .dbg_state(dbg_r));
  l2_arbiter #(.ADDR_W(24), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .bus(fb), .dbg_state(dbg_f));

  assign rb.i_addr = i_addr;  assign fb.i_addr = i_addr;
  assign rb.d_addr = d_addr;  assign fb.d_addr = d_addr;
  assign rb.d_data = d_data;  assign fb.d_data = d_data;
  assign rb.d_we   = d_we;    assign fb.d_we   = d_we;
  assign rb.i_start = i_start & ~use_fp;
  assign fb.i_start = i_start & use_fp;
  assign rb.d_start = d_start & ~use_fp;
  assign fb.d_start = d_start & use_fp;
  assign rb.l2_q = m_q;       assign fb.l2_q = m_q;
  assign rb.l2_done = m_done; assign fb.l2_done = m_done;

  logic [31:0] o_i_q, o_d_q, o_l2_data;
  logic [23:0] o_l2_addr;
  logic        o_i_done, o_d_done, o_l2_we, o_l2_start;
  assign o_i_q      = use_fp ? fb.i_q      : rb.i_q;
  assign o_i_done   = use_fp ? fb.i_done   : rb.i_done;
  assign o_d_q      = use_fp ? fb.d_q      : rb.d_q;
  assign o_d_done   = use_fp ? fb.d_done   : rb.d_done;
  assign o_l2_addr  = use_fp ? fb.l2_addr  : rb.l2_addr;
  assign o_l2_data  = use_fp ? fb.l2_data  : rb.l2_data;
  assign o_l2_we    = use_fp ? fb.l2_we    : rb.l2_we;
  assign o_l2_start = use_fp ? fb.l2_start : rb.l2_start;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required=<50000", cyc);
    $fatal(1);
  end

  // ---------------- L2 memory model ----------------
  logic [31:0] mem [logic [23:0]];
  int          m_lat = 4;
  int          cnt = 0;
  bit          chk_stable = 1'b1;
  int          stable_err = 0;
  logic        prev_start = 1'b0;
  logic [23:0] cap_addr = '0;
  logic [31:0] cap_data = '0;
  logic        cap_we = 1'b0;
  int          rise_cyc[$];
  logic [23:0] rise_addr[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    m_done = 1'b0;
    if (cnt > 0) begin
      if (chk_stable && (o_l2_addr !== cap_addr || o_l2_start !== 1'b1 ||
                         o_l2_we !== cap_we || o_l2_data !== cap_data))
        stable_err++;
      cnt--;
      if (cnt == 0) begin
        m_done = 1'b1;
        done_cyc.push_back(cyc);
        if (cap_we) begin
          mem[cap_addr] = cap_data;
          m_q = 32'h0;
        end else begin
          m_q = mem.exists(cap_addr) ? mem[cap_addr] : {8'hA5, cap_addr};
        end
      end
    end
    if (o_l2_start && !prev_start) begin
      cap_addr = o_l2_addr;
      cap_data = o_l2_data;
      cap_we   = o_l2_we;
      cnt      = m_lat;
      rise_cyc.push_back(cyc);
      rise_addr.push_back(o_l2_addr);
    end
    prev_start = o_l2_start;
  end

  // ---------------- done monitor / scoreboard ----------------
  logic [32:0] act_q[$];
  logic [32:0] exp_q[$];
  int i_done_cnt = 0;
  int d_done_cnt = 0;

  always @(negedge clk) begin
    if (o_i_done) begin act_q.push_back({1'b0, o_i_q}); i_done_cnt++; end
    if (o_d_done) begin act_q.push_back({1'b1, o_d_q}); d_done_cnt++; end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [23:0]];
  logic        m_last_d = 1'b0;

  function automatic logic [31:0] ref_read(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : {8'hA5, a};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    i_start = 1'b0;
    d_start = 1'b0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    m_last_d = 1'b0;
    act_q.delete();
  endtask

  task automatic wait_done(input string tag, input bit is_d, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      step(1);
      if ((is_d ? o_d_done : o_i_done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check(tag, 128'(at >= 0), 128'd1);
  endtask

  task automatic do_txn(input bit want_i, input bit want_d, input logic [23:0] ia,
                        input logic [23:0] da, input logic [31:0] dd, input bit dwe);
    bit d_first;
    bit is_d;
    logic [32:0] e;
    logic [32:0] a;
    d_first = (want_i && want_d) ? (use_fp ? 1'b1 : ~m_last_d) : want_d;
    for (int s = 0; s < 2; s++) begin
      is_d = (s == 0) ? d_first : ~d_first;
      if (is_d ? want_d : want_i) begin
        m_last_d = is_d;
        if (is_d && dwe) begin
          ref_mem[da] = dd;
          exp_q.push_back({1'b1, 32'h0});
        end else if (is_d) begin
          exp_q.push_back({1'b1, ref_read(da)});
        end else begin
          exp_q.push_back({1'b0, ref_read(ia)});
        end
      end
    end
    i_addr = ia; d_addr = da; d_data = dd; d_we = dwe;
    i_start = want_i; d_start = want_d;
    for (int k = 0; k < 80 && (i_start || d_start); k++) begin
      step(1);
      if (o_i_done) i_start = 1'b0;
      if (o_d_done) d_start = 1'b0;
    end
    check("txn_timeout", {i_start, d_start}, 2'b00);
    i_start = 1'b0; d_start = 1'b0;
    step(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : {33{1'bx}};
      check("txn_done", a, e);
    end
    check("txn_extra_done", act_q.size(), 0);
    act_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, at, r0, d0, ic, dc;
    int p;
    step(1);
    do_reset();
    check("rst_rr_outputs", {rb.i_q, rb.i_done, rb.d_q, rb.d_done, rb.l2_addr, rb.l2_data, rb.l2_we, rb.l2_start}, '0);
    check("rst_fp_outputs", {fb.i_q, fb.i_done, fb.d_q, fb.d_done, fb.l2_addr, fb.l2_data, fb.l2_we, fb.l2_start}, '0);
    check("rst_dbg_state", {dbg_r, dbg_f}, 4'h0);

    // T1: D read
    mem[24'h000123] = 32'hDEADBEEF;
    m_lat = 4;
    ic = i_done_cnt;
    d_addr = 24'h000123; d_we = 1'b0; d_start = 1'b1; n = cyc;
    step(1);
    check("t1_l2_start_rise", o_l2_start, 1'b1);
    check("t1_l2_addr", o_l2_addr, 24'h000123);
    check("t1_l2_we", o_l2_we, 1'b0);
    wait_done("t1_d_done_arrived", 1'b1, 30, at);
    check("t1_d_done_cycle", at, n + 1 + m_lat + 1);
    check("t1_d_q", o_d_q, 32'hDEADBEEF);
    check("t1_l2_start_low", o_l2_start, 1'b0);
    d_start = 1'b0;
    step(2);
    check("t1_no_i_done", i_done_cnt - ic, 0);
    check("t1_i_q_untouched", o_i_q, 32'h0);

    // T2: tie after reset, round robin -> D then I
    do_reset();
    r0 = rise_cyc.size(); d0 = done_cyc.size();
    i_addr = 24'h000010; d_addr = 24'h000020; d_we = 1'b0;
    i_start = 1'b1; d_start = 1'b1; n = cyc;
    for (int k = 0; k < 60 && (i_start || d_start); k++) begin
      step(1);
      if (o_i_done) i_start = 1'b0;
      if (o_d_done) d_start = 1'b0;
    end
    step(2);
    check("t2_done_count", act_q.size(), 2);
    check("t2_order", {act_q[0][32], act_q[1][32]}, 2'b10);
    check("t2_d_data", act_q[0][31:0], {8'hA5, 24'h000020});
    check("t2_i_data", act_q[1][31:0], {8'hA5, 24'h000010});
    check("t2_first_rise", rise_cyc[r0], n + 1);
    check("t2_rise_addrs", {rise_addr[r0], rise_addr[r0+1]}, {24'h000020, 24'h000010});
    check("t2_second_rise", rise_cyc[r0+1], done_cyc[d0] + 3);
    act_q.delete();

    // T4: I aborts 2 cycles into WAIT while D waits behind it
    m_lat = 6;
    stable_err = 0;
    ic = i_done_cnt; r0 = rise_cyc.size(); d0 = done_cyc.size();
    i_addr = 24'h000200; i_start = 1'b1; n = cyc;
    step(3);
    d_addr = 24'h000300; d_data = 32'h12345678; d_we = 1'b1; d_start = 1'b1;
    step(1);
    i_start = 1'b0;
    wait_done("t4_d_done_arrived", 1'b1, 40, at);
    d_start = 1'b0;
    step(2);
    check("t4_no_i_done", i_done_cnt - ic, 0);
    check("t4_l2_stable", stable_err, 0);
    check("t4_next_addr", rise_addr[r0+1], 24'h000300);
    check("t4_next_rise", rise_cyc[r0+1], done_cyc[d0] + 3);

    // T4b: aborted D write still lands in memory
    m_lat = 4;
    dc = d_done_cnt;
    d_addr = 24'h000301; d_data = 32'hCAFEF00D; d_we = 1'b1; d_start = 1'b1;
    step(4);
    d_start = 1'b0;
    i_addr = 24'h000301; i_start = 1'b1;
    wait_done("t4b_i_done_arrived", 1'b0, 40, at);
    check("t4b_i_q", o_i_q, 32'hCAFEF00D);
    i_start = 1'b0;
    step(2);
    check("t4b_no_d_done", d_done_cnt - dc, 0);
    act_q.delete();

    // T5: start held after done is not re-issued
    r0 = rise_cyc.size(); dc = d_done_cnt;
    d_addr = 24'h000005; d_we = 1'b0; d_start = 1'b1;
    wait_done("t5_d_done_arrived", 1'b1, 30, at);
    check("t5_d_q", o_d_q, ref_read(24'h000005));
    step(3);
    check("t5_no_reissue", rise_cyc.size(), r0 + 1);
    d_start = 1'b0;
    step(1);
    d_start = 1'b1; n = cyc;
    wait_done("t5_second_done", 1'b1, 30, at);
    d_start = 1'b0;
    step(2);
    check("t5_second_rise", rise_cyc[r0+1], n + 1);
    check("t5_done_count", d_done_cnt - dc, 2);
    act_q.delete();

    // T6: reset during WAIT of a D write, late l2_done ignored
    m_lat = 6;
    chk_stable = 1'b0;
    d_addr = 24'h000040; d_data = 32'h55AA55AA; d_we = 1'b1; d_start = 1'b1;
    step(3);
    reset = 1'b1; d_start = 1'b0;
    step(1);
    check("t6_rst_outputs", {rb.i_q, rb.i_done, rb.d_q, rb.d_done, rb.l2_addr, rb.l2_data, rb.l2_we, rb.l2_start}, '0);
    check("t6_rst_state", dbg_r, 2'd0);
    reset = 1'b0; m_last_d = 1'b0;
    dc = d_done_cnt;
    step(8);
    check("t6_late_done_ignored", d_done_cnt - dc, 0);
    check("t6_l2_start_idle", o_l2_start, 1'b0);
    chk_stable = 1'b1;

    // T3: fixed priority, D requests continuously for 3 transactions, then I
    use_fp = 1'b1;
    do_reset();
    m_lat = 3;
    r0 = rise_cyc.size();
    i_addr = 24'h000007; d_addr = 24'h000008; d_we = 1'b0;
    i_start = 1'b1; d_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done("t3_d_done_arrived", 1'b1, 30, at);
      d_start = 1'b0;
      step(1);
      if (k < 2) begin
        d_addr = d_addr + 24'd1;
        d_start = 1'b1;
      end
    end
    wait_done("t3_i_done_arrived", 1'b0, 30, at);
    i_start = 1'b0;
    step(2);
    check("t3_done_count", act_q.size(), 4);
    check("t3_order", {act_q[0][32], act_q[1][32], act_q[2][32], act_q[3][32]}, 4'b1110);
    check("t3_rise_addrs", {rise_addr[r0], rise_addr[r0+1], rise_addr[r0+2], rise_addr[r0+3]},
          {24'h000008, 24'h000009, 24'h00000A, 24'h000007});
    act_q.delete();

    // Random traffic on both arbitration modes
    for (int mode = 0; mode < 2; mode++) begin
      use_fp = (mode == 1);
      do_reset();
      for (int t = 0; t < 14; t++) begin
        p = $urandom_range(0, 2);
        m_lat = $urandom_range(2, 5);
        do_txn(p != 1, p != 0, 24'($urandom_range(0, 15)), 24'($urandom_range(0, 15)),
               $urandom, 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
